// File: rtl/number_scheduler.sv
// Converts a binary value to four BCD digits once per frame and, per pixel,
// steers the single-digit renderer to the active slot with leading-zero blanking.
module number_scheduler #(
   parameter int X_POS = 100,
   parameter int Y_POS = 40,
   parameter int NUM_W = 21,
   parameter int NUM_H = 23,
   parameter int GAP   = 3
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        frame_start,
   input  logic [13:0] value,
   input  logic [9:0]  x_px,
   input  logic [9:0]  y_px,
   output logic [9:0]  x_numbers,
   output logic [9:0]  y_numbers,
   output logic [3:0]  number,
   output logic        digit_en,
   output logic        busy,
   output logic        done
);

   localparam int PITCH = NUM_W + GAP;
   localparam logic [9:0] Y_LO = 10'(Y_POS);
   localparam logic [9:0] Y_HI = 10'(Y_POS + NUM_H);

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t      state, state_nxt;
   logic [13:0] bin_p0;
   logic [15:0] bcd_p0;
   logic [3:0]  cnt;
   logic        pending;
   logic [15:0] digits;
   logic        load;

   function automatic logic [13:0] clamp(input logic [13:0] v);
      return (v > 14'd9999) ? 14'd9999 : v;
   endfunction

   // One double-dabble iteration: correct each nibble, then shift {bcd,bin} left.
   function automatic logic [29:0] dabble(input logic [15:0] bcd, input logic [13:0] bin);
      logic [15:0] adj;
      for (int n = 0; n < 4; n++) begin
         adj[n*4 +: 4] = (bcd[n*4 +: 4] >= 4'd5) ? bcd[n*4 +: 4] + 4'd3 : bcd[n*4 +: 4];
      end
      return {adj[14:0], bin, 1'b0};
   endfunction

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_nxt = CONVERT;
               load      = 1'b1;
            end
         end
         CONVERT: begin
            if (cnt == 4'd13) state_nxt = COMMIT;
         end
         COMMIT: begin
            if (pending || frame_start) begin
               state_nxt = CONVERT;
               load      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Conversion stage: shift registers, request tracking, digit commit
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= IDLE;
         pending <= 1'b0;
         bin_p0  <= '0;
         bcd_p0  <= '0;
         cnt     <= '0;
         digits  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state != IDLE);
         done  <= (state == COMMIT);
         if (load) begin
            bin_p0 <= clamp(value);
            bcd_p0 <= '0;
            cnt    <= '0;
         end else if (state == CONVERT) begin
            {bcd_p0, bin_p0} <= dabble(bcd_p0, bin_p0);
            cnt              <= cnt + 4'd1;
         end
         if (state == COMMIT) digits <= bcd_p0;
         if (state == COMMIT)
            pending <= 1'b0;
         else if (state == CONVERT && frame_start)
            pending <= 1'b1;
      end
   end

   logic       hit;
   logic [1:0] hit_s;
   logic [9:0] slot_x;
   logic [3:0] slot_num;
   logic [3:0] blank;
   logic       y_in;

   always_comb begin
      hit    = 1'b0;
      hit_s  = 2'd0;
      slot_x = 10'(X_POS);
      for (int s = 0; s < 4; s++) begin
         if (x_px >= 10'(X_POS + s*PITCH) && x_px < 10'(X_POS + s*PITCH + NUM_W)) begin
            hit    = 1'b1;
            hit_s  = 2'(s);
            slot_x = 10'(X_POS + s*PITCH);
         end
      end
      // Slot 0 shows D3 (thousands); a slot blanks only if it and everything left are zero.
      blank[0] = (digits[15:12] == 4'd0);
      blank[1] = blank[0] && (digits[11:8] == 4'd0);
      blank[2] = blank[1] && (digits[7:4] == 4'd0);
      blank[3] = 1'b0;
      case (hit_s)
         2'd0:    slot_num = digits[15:12];
         2'd1:    slot_num = digits[11:8];
         2'd2:    slot_num = digits[7:4];
         default: slot_num = digits[3:0];
      endcase
      y_in = (y_px >= Y_LO) && (y_px < Y_HI);
   end

   // Slot-select output stage: one cycle behind x_px/y_px
   always_ff @(posedge clk) begin
      if (clr) begin
         x_numbers <= 10'(X_POS);
         number    <= 4'd0;
         digit_en  <= 1'b0;
      end else begin
         x_numbers <= hit ? slot_x : 10'(X_POS);
         number    <= hit ? slot_num : 4'd0;
         digit_en  <= hit && y_in && !blank[hit_s];
      end
   end

   assign y_numbers = 10'(Y_POS);

endmodule

// File: tb/tb_number_scheduler.sv
// Directed bench for number_scheduler: conversion timing, commit/pending, blanking, slot select.
module tb_number_scheduler;

   logic        clk = 1'b0;
   logic        clr;
   logic        frame_start;
   logic [13:0] value;
   logic [9:0]  x_px;
   logic [9:0]  y_px;
   logic [9:0]  x_numbers;
   logic [9:0]  y_numbers;
   logic [3:0]  number;
   logic        digit_en;
   logic        busy;
   logic        done;

   int n_chk  = 0;
   int n_pass = 0;

   number_scheduler dut (
      .clk(clk), .clr(clr), .frame_start(frame_start), .value(value),
      .x_px(x_px), .y_px(y_px), .x_numbers(x_numbers), .y_numbers(y_numbers),
      .number(number), .digit_en(digit_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input int x, input int y,
                        input int ex_x, input int ex_num, input int ex_en);
      x_px = 10'(x);
      y_px = 10'(y);
      step();
      check($sformatf("%s.x_numbers", tag), int'(x_numbers), ex_x);
      check($sformatf("%s.number", tag), int'(number), ex_num);
      check($sformatf("%s.digit_en", tag), int'(digit_en), ex_en);
   endtask

   task automatic convert(input string tag, input int v);
      value       = 14'(v);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (14) step();
      check($sformatf("%s.done_early", tag), int'(done), 0);
      step();
      check($sformatf("%s.done", tag), int'(done), 1);
      step();
      check($sformatf("%s.busy_end", tag), int'(busy), 0);
   endtask

   // Reference slot model: returns slot index 0..3 or -1 for gap/outside.
   function automatic int slot_of(input int x);
      for (int s = 0; s < 4; s++)
         if (x >= 100 + s*24 && x < 121 + s*24) return s;
      return -1;
   endfunction

   initial begin
      int bcnt, dcnt, dpos, first, second, errs_x, errs_n, errs_e, s;
      int dig[4];

      clr = 1'b1; frame_start = 1'b0; value = '0; x_px = '0; y_px = '0;

      // 1: reset state
      repeat (2) step();
      clr = 1'b0;
      check("rst.busy", int'(busy), 0);
      check("rst.done", int'(done), 0);
      check("rst.digit_en", int'(digit_en), 0);
      check("rst.x_numbers", int'(x_numbers), 100);
      check("rst.y_numbers", int'(y_numbers), 40);
      check("rst.number", int'(number), 0);
      probe("rst.slot3", 175, 50, 172, 0, 1);

      // 2: 1234 with busy/done timing
      value = 14'd1234; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      bcnt = 0; dcnt = 0; dpos = -1;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (busy) bcnt++;
         if (done) begin dcnt++; dpos = k; end
      end
      check("t2.busy_cycles", bcnt, 15);
      check("t2.done_pulses", dcnt, 1);
      check("t2.done_edge", dpos, 15);
      probe("t2.s0", 100, 50, 100, 1, 1);
      probe("t2.s1", 124, 50, 124, 2, 1);
      probe("t2.s2", 148, 50, 148, 3, 1);
      probe("t2.s3", 172, 50, 172, 4, 1);

      // 3: leading-zero blanking and gap
      convert("t3", 7);
      probe("t3.s0", 100, 50, 100, 0, 0);
      probe("t3.s1", 124, 50, 124, 0, 0);
      probe("t3.s2", 148, 50, 148, 0, 0);
      probe("t3.s3", 172, 50, 172, 7, 1);
      probe("t3.gap", 121, 50, 100, 0, 0);

      // 4: clamp, pending restart, no tearing during the second conversion
      value = 14'd12000; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (4) step();
      value = 14'd42; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      dcnt = 0; first = -1; second = -1;
      for (int k = 6; k <= 32; k++) begin
         if (k >= 16 && k <= 19) begin
            x_px = 10'(100 + 24*(k-16));
            y_px = 10'd50;
         end
         step();
         if (done) begin
            dcnt++;
            if (first < 0) first = k; else second = k;
         end
         if (k >= 16 && k <= 19) check($sformatf("t4.d9_s%0d", k-16), int'(number), 9);
      end
      check("t4.done_pulses", dcnt, 2);
      check("t4.first_done", first, 15);
      check("t4.second_done", second, 30);
      probe("t4.s0", 100, 50, 100, 0, 0);
      probe("t4.s1", 124, 50, 124, 0, 0);
      probe("t4.s2", 148, 50, 148, 4, 1);
      probe("t4.s3", 172, 50, 172, 2, 1);

      // 5: reset mid-conversion aborts without commit
      value = 14'd5678; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (7) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t5.busy", int'(busy), 0);
      check("t5.done", int'(done), 0);
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (done) dcnt++;
      end
      check("t5.no_done", dcnt, 0);
      check("t5.busy_idle", int'(busy), 0);
      probe("t5.s3", 172, 50, 172, 0, 1);
      probe("t5.s2", 148, 50, 148, 0, 0);

      // 6: row bounds and full-width sweep with one-cycle lag
      convert("t6", 1234);
      errs_e = 0;
      for (int x = 0; x < 1024; x++) begin
         x_px = 10'(x); y_px = 10'd39;
         step();
         if (digit_en) errs_e++;
         x_px = 10'(x); y_px = 10'd63;
         step();
         if (digit_en) errs_e++;
      end
      check("t6.row_edge_en", errs_e, 0);
      dig = '{1, 2, 3, 4};
      errs_x = 0; errs_n = 0; errs_e = 0;
      for (int x = 0; x < 1024; x++) begin
         x_px = 10'(x); y_px = 10'd50;
         step();
         s = slot_of(x);
         if (int'(x_numbers) != ((s < 0) ? 100 : 100 + 24*s)) errs_x++;
         if (int'(number) != ((s < 0) ? 0 : dig[s])) errs_n++;
         if (int'(digit_en) != ((s < 0) ? 0 : 1)) errs_e++;
      end
      check("t6.sweep_x", errs_x, 0);
      check("t6.sweep_num", errs_n, 0);
      check("t6.sweep_en", errs_e, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
